step_sequencer_n: RTL and testbench

//  Parametrised drum step sequencer: NUM_CH channels x NUM_STEPS-step patterns, replacing the fixed
//  4-instrument/8-step control+datapath+bpm trio. Phase-accumulator tempo generator (no divider)

---
 rtl/step_sequencer_n.sv | 172 +++++++++++++++++
 tb/tb_step_sequencer_n.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/step_sequencer_n.sv
// step_sequencer_n
//   Drum step sequencer: NUM_CH channels x NUM_STEPS-step patterns. A phase
//   accumulator turns the BPM input into step ticks without a divider. Each
//   tick advances the step index and fires one-cycle trig pulses for the
//   channels whose pattern bit is set and that are not muted.
//
// Ports
//   i_clk      system clock
//   i_reset    synchronous, active-low reset (overrides every other input)
//   i_start    pulse: (re)start from step 0 with an immediate step-0 trig
//   i_stop     pulse: stop and return to step 0
//   i_pause    pulse: toggle RUN <-> PAUSED (ignored while stopped)
//   i_bpm      tempo in BPM; 0 freezes the step index
//   i_len      active pattern length; 0 or > NUM_STEPS means NUM_STEPS
//   i_mute     per-channel trig suppression mask
//   i_wr_en    write i_wr_data into the pattern of channel i_wr_ch
//   i_wr_ch    channel index for write and readback
//   i_wr_data  pattern bits, bit i = step i
//   o_rd_data  registered pattern of channel i_wr_ch (write bypassed)
//   o_trig     one-cycle pulse per channel on an active step
//   o_step     current step index
//   o_step_tk  one-cycle pulse whenever a step is entered
//   o_playing  high while running
module step_sequencer_n #(
    parameter int              NUM_CH         = 4,
    parameter int              NUM_STEPS      = 8,
    parameter int              STEPS_PER_BEAT = 2,
    parameter longint unsigned CLK_HZ         = 50_000_000,
    parameter int              ACC_W          = 32,
    localparam int             STEP_W         = $clog2(NUM_STEPS)
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_start,
    input  logic                 i_stop,
    input  logic                 i_pause,
    input  logic [7:0]           i_bpm,
    input  logic [STEP_W:0]      i_len,
    input  logic [NUM_CH-1:0]    i_mute,
    input  logic                 i_wr_en,
    input  logic [3:0]           i_wr_ch,
    input  logic [NUM_STEPS-1:0] i_wr_data,
    output logic [NUM_STEPS-1:0] o_rd_data,
    output logic [NUM_CH-1:0]    o_trig,
    output logic [STEP_W-1:0]    o_step,
    output logic                 o_step_tk,
    output logic                 o_playing
);

    // One step per LIMIT accumulated units: inc = bpm*STEPS_PER_BEAT per clock,
    // and CLK_HZ*60 clocks per minute.
    localparam logic [ACC_W-1:0] LIMIT = ACC_W'(CLK_HZ * 64'd60);
    localparam logic [STEP_W:0]  FULL_LEN = (STEP_W+1)'(NUM_STEPS);

    typedef enum logic [1:0] {
        ST_STOP   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [ACC_W-1:0]      r_acc;
    logic [ACC_W-1:0]      w_acc_next;
    logic [STEP_W-1:0]     r_step;
    logic [STEP_W-1:0]     w_step_next;
    logic                  r_step_tk;
    logic                  w_tk_next;
    logic [NUM_CH-1:0]     r_trig;
    logic [NUM_CH-1:0]     w_trig_next;
    logic [NUM_STEPS-1:0]  r_rd_data;
    logic [NUM_STEPS-1:0]  w_rd_mux;
    logic [NUM_STEPS-1:0]  r_pat [NUM_CH];

    logic [ACC_W-1:0]      w_inc;
    logic [ACC_W:0]        w_sum;
    logic                  w_tick;
    logic [STEP_W:0]       w_eff_len;
    logic [STEP_W-1:0]     w_step_adv;
    logic                  w_wr_ok;

    // Tempo accumulator; one extra bit so acc+inc cannot wrap before compare.
    assign w_inc  = ACC_W'(i_bpm) * ACC_W'(STEPS_PER_BEAT);
    assign w_sum  = {1'b0, r_acc} + {1'b0, w_inc};
    assign w_tick = (w_sum >= {1'b0, LIMIT});

    // A length shrunk below the current step still wraps at the next tick
    // because the compare is >=, not ==.
    assign w_eff_len  = ((i_len == '0) || (i_len > FULL_LEN)) ? FULL_LEN : i_len;
    assign w_step_adv = ({1'b0, r_step} >= (w_eff_len - 1'b1)) ? '0 : r_step + 1'b1;

    assign w_wr_ok = i_wr_en && ({1'b0, i_wr_ch} < 5'(NUM_CH));

    always_comb begin
        w_state_next = r_state;
        w_acc_next   = r_acc;
        w_step_next  = r_step;
        w_tk_next    = 1'b0;
        if (i_stop) begin
            w_state_next = ST_STOP;
            w_acc_next   = '0;
            w_step_next  = '0;
        end else if (i_start) begin
            w_state_next = ST_RUN;
            w_acc_next   = '0;
            w_step_next  = '0;
            w_tk_next    = 1'b1;
        end else if (i_pause && (r_state == ST_RUN)) begin
            w_state_next = ST_PAUSED;
        end else if (i_pause && (r_state == ST_PAUSED)) begin
            // Resume without advancing: the accumulator picks up next cycle.
            w_state_next = ST_RUN;
        end else if (r_state == ST_RUN) begin
            if (w_tick) begin
                w_acc_next  = ACC_W'(w_sum - {1'b0, LIMIT});
                w_step_next = w_step_adv;
                w_tk_next   = 1'b1;
            end else begin
                w_acc_next  = ACC_W'(w_sum);
            end
        end
    end

    // Trig reads the stored pattern before any same-edge write lands.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_trig
        assign w_trig_next[gi] = w_tk_next & r_pat[gi][w_step_next] & ~i_mute[gi];
    end

    always_comb begin
        w_rd_mux = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (i_wr_ch == 4'(c)) begin
                w_rd_mux = r_pat[c];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state   <= ST_STOP;
            r_acc     <= '0;
            r_step    <= '0;
            r_step_tk <= 1'b0;
            r_trig    <= '0;
            r_rd_data <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                r_pat[c] <= '0;
            end
        end else begin
            r_state   <= w_state_next;
            r_acc     <= w_acc_next;
            r_step    <= w_step_next;
            r_step_tk <= w_tk_next;
            r_trig    <= w_trig_next;
            // Readback bypasses a write to the selected channel so the new
            // pattern is visible right after the write cycle.
            r_rd_data <= w_wr_ok ? i_wr_data : w_rd_mux;
            for (int c = 0; c < NUM_CH; c++) begin
                if (w_wr_ok && (i_wr_ch == 4'(c))) begin
                    r_pat[c] <= i_wr_data;
                end
            end
        end
    end

    assign o_rd_data = r_rd_data;
    assign o_trig    = r_trig;
    assign o_step    = r_step;
    assign o_step_tk = r_step_tk;
    assign o_playing = (r_state == ST_RUN);

endmodule

// File: tb/tb_step_sequencer_n.sv
module tb_step_sequencer_n;

    logic       clk = 1'b0;
    logic       reset, start, stop, pause, wr_en;
    logic [7:0] bpm;
    logic [3:0] len;
    logic [3:0] mute;
    logic [3:0] wr_ch;
    logic [7:0] wr_data;
    logic [7:0] rd_data;
    logic [3:0] trig;
    logic [2:0] step;
    logic       step_tk, playing;

    int checks = 0;
    int errors = 0;
    int s;
    logic [7:0] p0, p1;

    step_sequencer_n #(
        .NUM_CH(4), .NUM_STEPS(8), .STEPS_PER_BEAT(1), .CLK_HZ(1), .ACC_W(32)
    ) dut (
        .i_clk(clk), .i_reset(reset), .i_start(start), .i_stop(stop),
        .i_pause(pause), .i_bpm(bpm), .i_len(len), .i_mute(mute),
        .i_wr_en(wr_en), .i_wr_ch(wr_ch), .i_wr_data(wr_data),
        .o_rd_data(rd_data), .o_trig(trig), .o_step(step),
        .o_step_tk(step_tk), .o_playing(playing)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected trig for a step entered at index i: channels 0/1 carry patterns.
    function automatic logic [3:0] exp_trig(input int i);
        return {2'b00, p1[i] & ~mute[1], p0[i] & ~mute[0]};
    endfunction

    // Step once and check a tick landing on step s.
    task automatic tick_chk(input string tag);
        cyc();
        $display("%s step=%0d tk=%0b trig=%b", tag, step, step_tk, trig);
        chk({tag, "_step"}, 32'(step), 32'(s));
        chk({tag, "_tk"},   32'(step_tk), 32'd1);
        chk({tag, "_trig"}, 32'(trig), 32'(exp_trig(s)));
    endtask

    initial begin
        reset = 1'b0; start = 0; stop = 0; pause = 0; wr_en = 0;
        bpm = 0; len = 0; mute = 0; wr_ch = 0; wr_data = 0;
        p0 = 8'b0101_0101; p1 = 8'h0F;
        cyc(); cyc();
        chk("rst_trig", 32'(trig), 0);
        chk("rst_step", 32'(step), 0);
        chk("rst_play", 32'(playing), 0);
        chk("rst_tk",   32'(step_tk), 0);
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            wr_ch = 4'(c);
            cyc();
            chk("rst_rd", 32'(rd_data), 0);
        end

        // Pattern writes and read-after-write
        wr_en = 1; wr_ch = 0; wr_data = p0; cyc();
        chk("rd_ch0", 32'(rd_data), 32'(p0));
        wr_ch = 1; wr_data = p1; cyc();
        chk("rd_ch1", 32'(rd_data), 32'(p1));
        wr_ch = 5; wr_data = 8'hFF; cyc();
        wr_en = 0; wr_ch = 0; cyc();
        chk("rd_ch0_keep", 32'(rd_data), 32'(p0));

        // bpm=30: a step every 2 cycles, full 8-step wrap
        bpm = 30; start = 1; s = 0;
        tick_chk("start");
        start = 0;
        chk("playing", 32'(playing), 1);
        for (int k = 1; k <= 16; k++) begin
            cyc();
            chk("half_tk",   32'(step_tk), 0);
            chk("half_trig", 32'(trig), 0);
            chk("half_step", 32'(step), 32'(s));
            s = k % 8;
            tick_chk("run30");
        end

        // bpm=60, len=3: one step per cycle 0,1,2 wrap
        bpm = 60; len = 3;
        for (int k = 1; k <= 6; k++) begin
            s = k % 3;
            tick_chk("len3");
        end
        len = 0;
        for (int k = 1; k <= 8; k++) begin
            s = k % 8;
            tick_chk("len0");
        end

        // Mute channel 0 mid-run, then unmute
        mute = 4'b0001;
        for (int k = 1; k <= 4; k++) begin
            s = k;
            tick_chk("mute");
        end
        mute = 4'b0000;
        s = 5; tick_chk("unmute5");
        s = 6; tick_chk("unmute6");
        chk("unmute_trig0", 32'(trig[0]), 1);
        for (int k = 0; k < 7; k++) begin
            s = (s + 1) % 8;
            tick_chk("to5");
        end

        // Pause at step 5, hold, resume
        pause = 1; cyc(); pause = 0;
        chk("pause_play", 32'(playing), 0);
        chk("pause_step", 32'(step), 5);
        for (int k = 0; k < 10; k++) begin
            cyc();
            chk("paused_step", 32'(step), 5);
            chk("paused_trig", 32'(trig), 0);
            chk("paused_tk",   32'(step_tk), 0);
        end
        pause = 1; cyc(); pause = 0;
        chk("resume_play", 32'(playing), 1);
        chk("resume_tk",   32'(step_tk), 0);
        chk("resume_step", 32'(step), 5);
        s = 6; tick_chk("resume6");

        // bpm=0 freezes the step
        bpm = 0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("bpm0_step", 32'(step), 6);
            chk("bpm0_tk",   32'(step_tk), 0);
        end

        // Write coinciding with a tick: old bit drives that trig
        bpm = 60; wr_en = 1; wr_ch = 0; wr_data = 8'hFF;
        s = 7; tick_chk("wr_tick");
        wr_en = 0; p0 = 8'hFF;
        chk("wr_tick_rd", 32'(rd_data), 32'hFF);
        s = 0; tick_chk("wr_new0");
        s = 1; tick_chk("wr_new1");

        // Stop and start in the same cycle: stop wins
        stop = 1; start = 1; cyc(); stop = 0; start = 0;
        chk("ss_play", 32'(playing), 0);
        chk("ss_step", 32'(step), 0);
        chk("ss_tk",   32'(step_tk), 0);
        chk("ss_trig", 32'(trig), 0);
        pause = 1; cyc(); pause = 0;
        chk("stop_pause_play", 32'(playing), 0);
        cyc();
        chk("stop_hold_step", 32'(step), 0);
        start = 1; s = 0; tick_chk("restart"); start = 0;
        s = 1; tick_chk("restart1");
        stop = 1; cyc(); stop = 0;
        chk("stop_step", 32'(step), 0);
        chk("stop_play", 32'(playing), 0);

        // Reset overrides a start and clears the patterns
        reset = 0; start = 1; cyc(); reset = 1; start = 0;
        chk("rst2_play", 32'(playing), 0);
        chk("rst2_tk",   32'(step_tk), 0);
        wr_ch = 0; cyc();
        chk("rst2_rd", 32'(rd_data), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
